// File: rtl/bp_cfg_pkg.sv
// Shared types for the per-core configuration loader: field selector, entry layout, FSM encoding.
package bp_cfg_pkg;

   localparam int unsigned max_core_lp    = 16;
   localparam int unsigned core_idx_w_lp  = 4;
   localparam int unsigned state_w_lp     = 2;

   typedef enum logic [1:0] {
      e_field_freeze      = 2'd0,
      e_field_cce_mode    = 2'd1,
      e_field_icache_mode = 2'd2,
      e_field_dcache_mode = 2'd3
   } bp_cfg_field_e;

   // Packed so the bus view reads {dcache_mode, icache_mode, cce_mode, freeze}.
   typedef struct packed {
      logic dcache_mode;
      logic icache_mode;
      logic cce_mode;
      logic freeze;
   } bp_cfg_entry_s;

   typedef logic [state_w_lp-1:0] bp_cfg_state_t;

   localparam bp_cfg_state_t e_idle = 2'd0;
   localparam bp_cfg_state_t e_send = 2'd1;
   localparam bp_cfg_state_t e_resp = 2'd2;

   function automatic logic entry_field(input bp_cfg_entry_s entry, input bp_cfg_field_e field);
      logic val;
      val = entry.freeze;
      case (field)
         e_field_freeze:      val = entry.freeze;
         e_field_cce_mode:    val = entry.cce_mode;
         e_field_icache_mode: val = entry.icache_mode;
         e_field_dcache_mode: val = entry.dcache_mode;
         default:             val = entry.freeze;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/bp_cfg_entry.sv
// One core's configuration register; a write updates only the selected field bit.
module bp_cfg_entry
   import bp_cfg_pkg::*;
#(
   parameter logic default_freeze_p   = 1'b1,
   parameter logic default_cce_mode_p = 1'b0
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          we_i,
   input  bp_cfg_field_e field_i,
   input  logic          bit_i,
   output bp_cfg_entry_s entry_o
);

   bp_cfg_entry_s entry_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         entry_r.dcache_mode <= 1'b0;
         entry_r.icache_mode <= 1'b0;
         entry_r.cce_mode    <= default_cce_mode_p;
         entry_r.freeze      <= default_freeze_p;
      end else if (we_i) begin
         case (field_i)
            e_field_freeze:      entry_r.freeze      <= bit_i;
            e_field_cce_mode:    entry_r.cce_mode    <= bit_i;
            e_field_icache_mode: entry_r.icache_mode <= bit_i;
            e_field_dcache_mode: entry_r.dcache_mode <= bit_i;
            default:             entry_r.freeze      <= bit_i;
         endcase
      end
   end

   assign entry_o = entry_r;

endmodule

// File: rtl/bp_cfg_loader.sv
// Host-facing config loader: updates per-core entries, then delivers them to cores one at a time.
module bp_cfg_loader
   import bp_cfg_pkg::*;
#(
   parameter int unsigned num_core_p         = 4,
   parameter int unsigned cfg_data_width_p   = 8,
   parameter int unsigned default_freeze_p   = 1,
   parameter int unsigned default_cce_mode_p = 0
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        cfg_v_i,
   output logic                        cfg_ready_o,
   input  logic                        cfg_w_i,
   input  logic [4:0]                  cfg_core_i,
   input  logic [1:0]                  cfg_field_i,
   input  logic [cfg_data_width_p-1:0] cfg_data_i,
   output logic                        resp_v_o,
   output logic [cfg_data_width_p-1:0] resp_data_o,
   output logic                        resp_err_o,
   input  logic                        resp_yumi_i,
   output logic                        bus_v_o,
   output logic [3:0]                  bus_core_o,
   output logic [3:0]                  bus_entry_o,
   input  logic [num_core_p-1:0]       bus_ack_i,
   output logic [num_core_p-1:0]       freeze_o
);

   localparam logic [core_idx_w_lp:0]   num_core_lp  = (core_idx_w_lp+1)'(num_core_p);
   localparam logic [core_idx_w_lp-1:0] last_core_lp = core_idx_w_lp'(num_core_p - 1);

   bp_cfg_state_t               state_r, state_n;
   logic [core_idx_w_lp-1:0]    iter_r, iter_n;
   logic                        bcast_r, bcast_n;
   logic                        resp_bit_r, resp_bit_n;
   logic                        resp_err_r, resp_err_n;
   logic [num_core_p-1:0]       we_c;

   bp_cfg_entry_s [max_core_lp-1:0] entry_arr;
   logic [max_core_lp-1:0]          ack_pad;
   logic [cfg_data_width_p-1:0]     cfg_data_unused;

   logic                     accept_c;
   logic                     bcast_c;
   logic                     idx_valid_c;
   logic [core_idx_w_lp-1:0] idx_c;
   bp_cfg_field_e            field_c;

   assign idx_c           = cfg_core_i[3:0];
   assign bcast_c         = cfg_core_i[4];
   assign idx_valid_c     = ({1'b0, idx_c} < num_core_lp);
   assign field_c         = bp_cfg_field_e'(cfg_field_i);
   assign ack_pad         = max_core_lp'(bus_ack_i);
   assign cfg_data_unused = cfg_data_i;

   // Ready is a state decode, held low while reset is asserted.
   assign cfg_ready_o = (state_r == e_idle) && reset_n_i;
   assign accept_c    = cfg_v_i && cfg_ready_o;

   // Unused slots read back as zero so the 4-bit index never needs narrowing.
   for (genvar i = 0; i < max_core_lp; i++) begin : g_core
      if (i < num_core_p) begin : g_live
         bp_cfg_entry #(
            .default_freeze_p   (1'(default_freeze_p)),
            .default_cce_mode_p (1'(default_cce_mode_p))
         ) u_entry (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .we_i      (we_c[i]),
            .field_i   (field_c),
            .bit_i     (cfg_data_i[0]),
            .entry_o   (entry_arr[i])
         );
         assign freeze_o[i] = entry_arr[i].freeze;
      end else begin : g_pad
         assign entry_arr[i] = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r    <= e_idle;
         iter_r     <= '0;
         bcast_r    <= 1'b0;
         resp_bit_r <= 1'b0;
         resp_err_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         iter_r     <= iter_n;
         bcast_r    <= bcast_n;
         resp_bit_r <= resp_bit_n;
         resp_err_r <= resp_err_n;
      end
   end

   always_comb begin
      state_n    = state_r;
      iter_n     = iter_r;
      bcast_n    = bcast_r;
      resp_bit_n = resp_bit_r;
      resp_err_n = resp_err_r;
      we_c       = '0;

      case (state_r)
         e_idle: begin
            if (accept_c) begin
               resp_bit_n = 1'b0;
               resp_err_n = 1'b0;
               state_n    = e_resp;
               if (cfg_w_i && (bcast_c || idx_valid_c)) begin
                  state_n = e_send;
                  bcast_n = bcast_c;
                  iter_n  = bcast_c ? '0 : idx_c;
                  for (int unsigned i = 0; i < num_core_p; i++) begin
                     we_c[i] = bcast_c || (idx_c == core_idx_w_lp'(i));
                  end
               end else if (!cfg_w_i && !bcast_c && idx_valid_c) begin
                  resp_bit_n = entry_field(entry_arr[idx_c], field_c);
               end else begin
                  resp_err_n = 1'b1;
               end
            end
         end
         e_send: begin
            // Only the ack bit of the core being delivered counts.
            if (ack_pad[iter_r]) begin
               if (!bcast_r || (iter_r == last_core_lp)) begin
                  state_n = e_resp;
               end else begin
                  iter_n = iter_r + 4'd1;
               end
            end
         end
         e_resp: begin
            if (resp_yumi_i) begin
               state_n = e_idle;
               iter_n  = '0;
            end
         end
         default: begin
            state_n = e_idle;
            iter_n  = '0;
         end
      endcase
   end

   assign resp_v_o    = (state_r == e_resp);
   assign resp_data_o = resp_v_o ? cfg_data_width_p'(resp_bit_r) : '0;
   assign resp_err_o  = resp_v_o && resp_err_r;
   assign bus_v_o     = (state_r == e_send);
   assign bus_core_o  = iter_r;
   assign bus_entry_o = bus_v_o ? entry_arr[iter_r] : 4'h0;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader with four cores and default reset values.
module tb_bp_cfg_loader;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       cfg_v_i;
   logic       cfg_ready_o;
   logic       cfg_w_i;
   logic [4:0] cfg_core_i;
   logic [1:0] cfg_field_i;
   logic [7:0] cfg_data_i;
   logic       resp_v_o;
   logic [7:0] resp_data_o;
   logic       resp_err_o;
   logic       resp_yumi_i;
   logic       bus_v_o;
   logic [3:0] bus_core_o;
   logic [3:0] bus_entry_o;
   logic [3:0] bus_ack_i;
   logic [3:0] freeze_o;

   int checks   = 0;
   int failures = 0;

   bp_cfg_loader #(
      .num_core_p         (4),
      .cfg_data_width_p   (8),
      .default_freeze_p   (1),
      .default_cce_mode_p (0)
   ) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .cfg_v_i     (cfg_v_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_w_i     (cfg_w_i),
      .cfg_core_i  (cfg_core_i),
      .cfg_field_i (cfg_field_i),
      .cfg_data_i  (cfg_data_i),
      .resp_v_o    (resp_v_o),
      .resp_data_o (resp_data_o),
      .resp_err_o  (resp_err_o),
      .resp_yumi_i (resp_yumi_i),
      .bus_v_o     (bus_v_o),
      .bus_core_o  (bus_core_o),
      .bus_entry_o (bus_entry_o),
      .bus_ack_i   (bus_ack_i),
      .freeze_o    (freeze_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic request(input logic w, input logic [4:0] core, input logic [1:0] field,
                          input logic [7:0] data);
      cfg_v_i     = 1'b1;
      cfg_w_i     = w;
      cfg_core_i  = core;
      cfg_field_i = field;
      cfg_data_i  = data;
      tick();
      cfg_v_i     = 1'b0;
      cfg_data_i  = 8'h00;
   endtask

   task automatic consume();
      resp_yumi_i = 1'b1;
      tick();
      resp_yumi_i = 1'b0;
   endtask

   logic [3:0] exp_entry [4];
   logic [3:0] onehot;

   initial begin
      reset_n_i   = 1'b0;
      cfg_v_i     = 1'b0;
      cfg_w_i     = 1'b0;
      cfg_core_i  = 5'd0;
      cfg_field_i = 2'd0;
      cfg_data_i  = 8'h00;
      resp_yumi_i = 1'b0;
      bus_ack_i   = 4'h0;
      repeat (2) tick();

      check("rst_ready",  32'(cfg_ready_o), 32'h0);
      check("rst_bus_v",  32'(bus_v_o),     32'h0);
      check("rst_resp_v", 32'(resp_v_o),    32'h0);
      check("rst_freeze", 32'(freeze_o),    32'hF);

      // Read core 2 freeze on the first edge after release.
      reset_n_i = 1'b1;
      #1;
      check("rel_ready", 32'(cfg_ready_o), 32'h1);
      request(1'b0, 5'd2, 2'd0, 8'h00);
      check("rd_resp_v", 32'(resp_v_o),    32'h1);
      check("rd_data",   32'(resp_data_o), 32'h1);
      check("rd_err",    32'(resp_err_o),  32'h0);
      check("rd_ready",  32'(cfg_ready_o), 32'h0);
      check("rd_bus_v",  32'(bus_v_o),     32'h0);
      consume();
      check("rd_done_v",     32'(resp_v_o),    32'h0);
      check("rd_done_ready", 32'(cfg_ready_o), 32'h1);

      // Unicast write core 1 cce_mode with ack in the first send cycle.
      request(1'b1, 5'd1, 2'd1, 8'h01);
      check("w1_bus_v",  32'(bus_v_o),     32'h1);
      check("w1_core",   32'(bus_core_o),  32'h1);
      check("w1_entry",  32'(bus_entry_o), 32'h3);
      check("w1_resp_v", 32'(resp_v_o),    32'h0);
      bus_ack_i = 4'b0010;
      tick();
      bus_ack_i = 4'h0;
      check("w1_resp_v2", 32'(resp_v_o),    32'h1);
      check("w1_err",     32'(resp_err_o),  32'h0);
      check("w1_data",    32'(resp_data_o), 32'h0);
      check("w1_bus_off", 32'(bus_v_o),     32'h0);
      consume();

      // Upper data bits ignored: 0xFE clears core 0 freeze.
      request(1'b1, 5'd0, 2'd0, 8'hFE);
      check("w0_freeze", 32'(freeze_o),    32'hE);
      check("w0_entry",  32'(bus_entry_o), 32'h0);
      bus_ack_i = 4'b0001;
      tick();
      bus_ack_i = 4'h0;
      check("w0_resp_v", 32'(resp_v_o), 32'h1);
      consume();

      // Broadcast freeze=0, each core acked after three cycles of foreign acks.
      exp_entry[0] = 4'b0000;
      exp_entry[1] = 4'b0010;
      exp_entry[2] = 4'b0000;
      exp_entry[3] = 4'b0000;
      request(1'b1, 5'h10, 2'd0, 8'h00);
      check("bc_freeze", 32'(freeze_o), 32'h0);
      for (int k = 0; k < 4; k++) begin
         onehot = 4'b0001 << k;
         for (int c = 0; c < 3; c++) begin
            check($sformatf("bc_v_%0d_%0d", k, c),    32'(bus_v_o),     32'h1);
            check($sformatf("bc_core_%0d_%0d", k, c), 32'(bus_core_o),  32'(k));
            check($sformatf("bc_ent_%0d_%0d", k, c),  32'(bus_entry_o), 32'(exp_entry[k]));
            bus_ack_i = ~onehot;
            tick();
         end
         check($sformatf("bc_hold_%0d", k), 32'(bus_core_o), 32'(k));
         bus_ack_i = onehot;
         tick();
         bus_ack_i = 4'h0;
      end
      check("bc_resp_v", 32'(resp_v_o),   32'h1);
      check("bc_err",    32'(resp_err_o), 32'h0);
      consume();

      // Nonexistent core 9.
      request(1'b1, 5'd9, 2'd0, 8'h01);
      check("bad_resp_v", 32'(resp_v_o),   32'h1);
      check("bad_err",    32'(resp_err_o), 32'h1);
      check("bad_bus_v",  32'(bus_v_o),    32'h0);
      check("bad_freeze", 32'(freeze_o),   32'h0);
      consume();

      // Broadcast read is an error.
      request(1'b0, 5'h10, 2'd1, 8'h00);
      check("bcr_err",  32'(resp_err_o),  32'h1);
      check("bcr_data", 32'(resp_data_o), 32'h0);
      consume();

      // Response held for 10 cycles without yumi.
      request(1'b0, 5'd1, 2'd1, 8'h00);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("hold_v_%0d", i),     32'(resp_v_o),    32'h1);
         check($sformatf("hold_data_%0d", i),  32'(resp_data_o), 32'h1);
         check($sformatf("hold_ready_%0d", i), 32'(cfg_ready_o), 32'h0);
         tick();
      end
      consume();
      check("hold_done_ready", 32'(cfg_ready_o), 32'h1);

      // Reset while the broadcast is delivering core 2.
      request(1'b1, 5'h1F, 2'd2, 8'h01);
      bus_ack_i = 4'b0001;
      tick();
      bus_ack_i = 4'b0010;
      tick();
      bus_ack_i = 4'h0;
      check("mb_core", 32'(bus_core_o), 32'h2);
      check("mb_v",    32'(bus_v_o),    32'h1);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("mb_rst_bus_v",  32'(bus_v_o),     32'h0);
      check("mb_rst_freeze", 32'(freeze_o),    32'hF);
      check("mb_rst_ready",  32'(cfg_ready_o), 32'h0);
      check("mb_rst_resp_v", 32'(resp_v_o),    32'h0);
      tick();
      reset_n_i = 1'b1;
      #1;
      check("mb_rel_ready", 32'(cfg_ready_o), 32'h1);
      check("mb_rel_bus_v", 32'(bus_v_o),     32'h0);
      request(1'b0, 5'd0, 2'd2, 8'h00);
      check("mb_rd_v",    32'(resp_v_o),    32'h1);
      check("mb_rd_data", 32'(resp_data_o), 32'h0);
      consume();
      request(1'b0, 5'd1, 2'd1, 8'h00);
      check("mb_rd_cce", 32'(resp_data_o), 32'h0);
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
